// File: rtl/mem_stage_cached.sv
// Purpose: direct-mapped write-through, no-write-allocate data cache with a built-in 16-bit async SRAM sequencer.
// Latency: load hit 0 cycles; load miss 2*LINE_WORDS*(WAIT_CYCLES+1)+1 frozen cycles; store 2*(WAIT_CYCLES+1)+1 frozen cycles.
// Backpressure: freeze_signal stalls the pipeline, which holds the request stable; a request seen in DONE is ignored.
module mem_stage_cached #(
    parameter int          SETS        = 64,
    parameter int          LINE_WORDS  = 2,
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEMread,
    input  logic        MEMwrite,
    input  logic        WB_EN,
    input  logic [31:0] address,
    input  logic [31:0] data,
    output logic [31:0] MEM_result,
    output logic        freeze_signal,
    output logic        WB_EN_Out,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N
);
    localparam int OFFB = $clog2(LINE_WORDS);
    localparam int IDXB = $clog2(SETS);
    localparam int TAGB = 17 - OFFB - IDXB;
    localparam int OFFW = (OFFB > 0) ? OFFB : 1;
    localparam int HWN  = 2 * LINE_WORDS;
    localparam int HB   = $clog2(HWN);

    localparam logic [16:0]   OFF_MASK  = 17'(LINE_WORDS - 1);
    localparam logic [3:0]    W_LAST    = 4'(WAIT_CYCLES);
    localparam logic [HB-1:0] H_LAST_RD = HB'(HWN - 1);
    localparam logic [HB-1:0] H_LAST_WR = HB'(1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t state;
    logic [HB-1:0] h;
    logic [3:0]    w;

    logic [SETS-1:0] valid;
    logic [TAGB-1:0] tag_mem   [SETS];
    logic [31:0]     cache_mem [SETS][LINE_WORDS];

    logic [HWN-1:0][15:0] line_buf;
    logic [HWN-1:0][15:0] fill_line;

    // Address decomposition: SRAM word address relative to the data-memory base
    logic [31:0]     rel;
    logic [16:0]     wa;
    logic [16:0]     wa_line;
    logic [16:0]     wa_tag;
    logic [16:0]     off17;
    logic [IDXB-1:0] idx;
    logic [TAGB-1:0] tag;
    logic [OFFW-1:0] off;
    logic [17:0]     line_base_hw;
    logic [17:0]     word_base_hw;
    logic            hit;
    logic            slot_end;
    logic            unused_bits;

    assign rel          = address - BASE_ADDR;
    assign wa           = rel[18:2];
    assign wa_line      = wa >> OFFB;
    assign wa_tag       = wa >> (OFFB + IDXB);
    assign off17        = wa & OFF_MASK;
    assign idx          = wa_line[IDXB-1:0];
    assign tag          = wa_tag[TAGB-1:0];
    assign off          = off17[OFFW-1:0];
    assign line_base_hw = {wa & ~OFF_MASK, 1'b0};
    assign word_base_hw = {wa, 1'b0};
    assign unused_bits  = &{1'b0, rel[31:19], rel[1:0], wa_line[16:IDXB], wa_tag[16:TAGB], off17[16:OFFW]};

    assign hit      = valid[idx] && (tag_mem[idx] == tag);
    assign slot_end = (w == W_LAST);

    // Line as it will be after this cycle's sample, so the last halfword lands in the cache directly
    always_comb begin
        fill_line    = line_buf;
        fill_line[h] = SRAM_DQ;
    end

    // Sequencer: slot/halfword counters, state and valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            h        <= '0;
            w        <= '0;
            valid    <= '0;
            line_buf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    h <= '0;
                    w <= '0;
                    if (MEMwrite)
                        state <= WRITE;
                    else if (MEMread && !hit)
                        state <= FILL;
                end
                FILL: begin
                    if (slot_end) begin
                        line_buf[h] <= SRAM_DQ;
                        w           <= '0;
                        if (h == H_LAST_RD) begin
                            h          <= '0;
                            valid[idx] <= 1'b1;
                            state      <= DONE;
                        end else begin
                            h <= h + 1'b1;
                        end
                    end else begin
                        w <= w + 1'b1;
                    end
                end
                WRITE: begin
                    if (slot_end) begin
                        w <= '0;
                        if (h == H_LAST_WR) begin
                            h     <= '0;
                            state <= DONE;
                        end else begin
                            h <= h + 1'b1;
                        end
                    end else begin
                        w <= w + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Cache array: store-hit update on WRITE entry, whole-line install at the end of a fill
    always_ff @(posedge clk) begin
        if (state == IDLE && MEMwrite && hit)
            cache_mem[idx][off] <= data;
        if (state == FILL && slot_end && h == H_LAST_RD) begin
            tag_mem[idx] <= tag;
            for (int k = 0; k < LINE_WORDS; k++)
                cache_mem[idx][k] <= {fill_line[2*k+1], fill_line[2*k]};
        end
    end

    // Pipeline-facing outputs
    always_comb begin
        case (state)
            IDLE:    freeze_signal = MEMwrite | (MEMread & ~hit);
            FILL:    freeze_signal = 1'b1;
            WRITE:   freeze_signal = 1'b1;
            default: freeze_signal = 1'b0;
        endcase
    end

    assign WB_EN_Out  = WB_EN & ~freeze_signal;
    assign MEM_result = cache_mem[idx][off];

    // SRAM-facing outputs decoded from the registered state and counters
    always_comb begin
        case (state)
            FILL:    SRAM_ADDR = line_base_hw + 18'(h);
            WRITE:   SRAM_ADDR = word_base_hw + 18'(h);
            default: SRAM_ADDR = '0;
        endcase
    end

    assign SRAM_WE_N = !(state == WRITE && !slot_end);
    assign SRAM_OE_N = !(state == FILL);
    assign SRAM_DQ   = (state == WRITE) ? (h[0] ? data[31:16] : data[15:0]) : 16'hzzzz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;

endmodule

// File: tb/tb_mem_stage_cached.sv
// Purpose: directed checks of two cache configurations (default, and 4-word lines with 1 wait state) against SRAM models.
// Latency: each request is held until freeze drops; frozen cycles are counted and compared.
// Backpressure: the bench behaves as the pipeline, holding the request stable while frozen.
module tb_mem_stage_cached;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       mr, mw, wb;
    logic [1:0][31:0] ad, dt;
    wire  [1:0][31:0] res;
    wire  [1:0]       frz, wbo, we_n, oe_n, ub_n, lb_n, ce_n;
    wire  [1:0][17:0] sa;
    wire  [15:0]      dq0, dq1;

    mem_stage_cached u0 (
        .clk(clk), .rst(rst), .MEMread(mr[0]), .MEMwrite(mw[0]), .WB_EN(wb[0]),
        .address(ad[0]), .data(dt[0]), .MEM_result(res[0]), .freeze_signal(frz[0]),
        .WB_EN_Out(wbo[0]), .SRAM_DQ(dq0), .SRAM_ADDR(sa[0]), .SRAM_UB_N(ub_n[0]),
        .SRAM_LB_N(lb_n[0]), .SRAM_CE_N(ce_n[0]), .SRAM_WE_N(we_n[0]), .SRAM_OE_N(oe_n[0])
    );

    mem_stage_cached #(.LINE_WORDS(4), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .MEMread(mr[1]), .MEMwrite(mw[1]), .WB_EN(wb[1]),
        .address(ad[1]), .data(dt[1]), .MEM_result(res[1]), .freeze_signal(frz[1]),
        .WB_EN_Out(wbo[1]), .SRAM_DQ(dq1), .SRAM_ADDR(sa[1]), .SRAM_UB_N(ub_n[1]),
        .SRAM_LB_N(lb_n[1]), .SRAM_CE_N(ce_n[1]), .SRAM_WE_N(we_n[1]), .SRAM_OE_N(oe_n[1])
    );

    // SRAM models: read while OE low, write captured while WE low
    logic [15:0] mem0 [4096];
    logic [15:0] mem1 [4096];
    assign dq0 = (!oe_n[0] && we_n[0]) ? mem0[sa[0][11:0]] : 16'hzzzz;
    assign dq1 = (!oe_n[1] && we_n[1]) ? mem1[sa[1][11:0]] : 16'hzzzz;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem0[i] = 16'h0100 + i[15:0];
            mem1[i] = 16'h0200 + i[15:0];
        end
        mem0[0] = 16'h5678;  mem0[1] = 16'h1234;
        mem0[256] = 16'hAAAA; mem0[257] = 16'h5555;
        mem1[0] = 16'h5678;  mem1[1] = 16'h1234;
        mem1[6] = 16'hF00D;  mem1[7] = 16'hCAFE;
        forever begin
            @(negedge clk);
            if (!we_n[0]) mem0[sa[0][11:0]] = dq0;
            if (!we_n[1]) mem1[sa[1][11:0]] = dq1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [17:0] t_addr [256];
    logic        t_we   [256];
    logic [15:0] t_dq   [256];
    int          wbo_bad;

    // Present one request, count frozen cycles, capture result in the first unfrozen cycle
    task automatic req(input int i, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, output int nf, output logic [31:0] r, output logic wdone);
        logic done;
        @(posedge clk); #1;
        mr[i] = rd; mw[i] = wr; ad[i] = a; dt[i] = d; wb[i] = 1'b1;
        nf = 0; wbo_bad = 0; done = 1'b0; r = '0; wdone = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            t_addr[c] = sa[i];
            t_we[c]   = we_n[i];
            t_dq[c]   = (i == 0) ? dq0 : dq1;
            if (frz[i]) begin
                nf++;
                if (wbo[i]) wbo_bad++;
            end else begin
                done  = 1'b1;
                r     = res[i];
                wdone = wbo[i];
            end
        end
        chk("req_completed", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        mr[i] = 1'b0; mw[i] = 1'b0; wb[i] = 1'b0;
    endtask

    task automatic do_reset;
        mr = '0; mw = '0; wb = '0; ad = '0; dt = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int          nf;
    logic [31:0] r;
    logic        wd;
    int          we_low;

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_freeze", {31'd0, frz[0]}, 32'd0);
        chk("rst_oe_we", {30'd0, oe_n[0], we_n[0]}, 32'd3);
        chk("rst_addr", {14'd0, sa[0]}, 32'd0);
        chk("rst_ub_lb_ce", {29'd0, ub_n[0], lb_n[0], ce_n[0]}, 32'd0);

        // Load miss from 1024: 25 frozen cycles, halfword addresses 0..3 in 6-cycle slots
        req(0, 1, 0, 32'd1024, 32'd0, nf, r, wd);
        chk("ld_miss_freeze", nf, 32'd25);
        chk("ld_miss_addr_c1", {14'd0, t_addr[1]}, 32'd0);
        chk("ld_miss_addr_c6", {14'd0, t_addr[6]}, 32'd0);
        chk("ld_miss_addr_c7", {14'd0, t_addr[7]}, 32'd1);
        chk("ld_miss_addr_c13", {14'd0, t_addr[13]}, 32'd2);
        chk("ld_miss_addr_c19", {14'd0, t_addr[19]}, 32'd3);
        chk("ld_miss_data", r, 32'h12345678);
        chk("ld_miss_wbo_frozen", wbo_bad, 32'd0);
        req(0, 1, 0, 32'd1024, 32'd0, nf, r, wd);
        chk("ld_hit_freeze", nf, 32'd0);
        chk("ld_hit_data", r, 32'h12345678);
        chk("ld_hit_wbo", {31'd0, wd}, 32'd1);

        // Store miss to 1032: halfwords 4,5; WE low 5 of each 6 cycles
        req(0, 0, 1, 32'd1032, 32'hDEADBEEF, nf, r, wd);
        chk("st_freeze", nf, 32'd13);
        chk("st_addr_c1", {14'd0, t_addr[1]}, 32'd4);
        chk("st_addr_c7", {14'd0, t_addr[7]}, 32'd5);
        chk("st_dq_c1", {16'd0, t_dq[1]}, 32'hBEEF);
        chk("st_dq_c7", {16'd0, t_dq[7]}, 32'hDEAD);
        chk("st_we_c5", {31'd0, t_we[5]}, 32'd0);
        chk("st_we_c6", {31'd0, t_we[6]}, 32'd1);
        we_low = 0;
        for (int c = 0; c <= 12; c++) if (!t_we[c]) we_low++;
        chk("st_we_low_count", we_low, 32'd10);
        req(0, 1, 0, 32'd1032, 32'd0, nf, r, wd);
        chk("ld_after_st_freeze", nf, 32'd25);
        chk("ld_after_st_data", r, 32'hDEADBEEF);

        // Store hit updates the cached line
        do_reset();
        req(0, 1, 0, 32'd1024, 32'd0, nf, r, wd);
        chk("fill_freeze", nf, 32'd25);
        req(0, 0, 1, 32'd1028, 32'hCAFEF00D, nf, r, wd);
        chk("st_hit_freeze", nf, 32'd13);
        req(0, 1, 0, 32'd1028, 32'd0, nf, r, wd);
        chk("st_hit_ld_freeze", nf, 32'd0);
        chk("st_hit_ld_data", r, 32'hCAFEF00D);
        req(0, 1, 0, 32'd1024, 32'd0, nf, r, wd);
        chk("st_hit_neighbour", r, 32'h12345678);

        // Conflict on index 0
        req(0, 1, 0, 32'd1536, 32'd0, nf, r, wd);
        chk("conflict_freeze", nf, 32'd25);
        chk("conflict_data", r, 32'h5555AAAA);
        req(0, 1, 0, 32'd1024, 32'd0, nf, r, wd);
        chk("conflict_reload_freeze", nf, 32'd25);
        chk("conflict_reload_data", r, 32'h12345678);

        // Reset in the middle of a fill
        do_reset();
        @(posedge clk); #1;
        mr[0] = 1'b1; ad[0] = 32'd1024;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_oe", {31'd0, oe_n[0]}, 32'd1);
        chk("midrst_we", {31'd0, we_n[0]}, 32'd1);
        chk("midrst_addr", {14'd0, sa[0]}, 32'd0);
        mr[0] = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        req(0, 1, 0, 32'd1024, 32'd0, nf, r, wd);
        chk("midrst_reload_freeze", nf, 32'd25);
        chk("midrst_reload_data", r, 32'h12345678);

        // Four-word lines, one wait state
        req(1, 1, 0, 32'd1024, 32'd0, nf, r, wd);
        chk("lw4_freeze", nf, 32'd17);
        for (int k = 0; k < 8; k++)
            chk($sformatf("lw4_addr_%0d", k), {14'd0, t_addr[1 + 2*k]}, k);
        chk("lw4_wbo_frozen", wbo_bad, 32'd0);
        chk("lw4_wbo_done", {31'd0, wd}, 32'd1);
        chk("lw4_data", r, 32'h12345678);
        req(1, 1, 0, 32'd1036, 32'd0, nf, r, wd);
        chk("lw4_hit_freeze", nf, 32'd0);
        chk("lw4_hit_data", r, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_cached.md
# mem_stage_cached

Parametrised memory stage for the ARM pipeline: a direct-mapped, write-through, no-write-allocate data cache in front of a 16-bit asynchronous SRAM, with the SRAM sequencer built in.
- Cache geometry, line size, SRAM wait states and the data-memory base address are parameters.
- Sits between the EXE/MEM and MEM/WB pipeline registers.
- Stalls the whole pipeline through `freeze_signal` while an SRAM access is in progress.
- Suppresses write-back while frozen.

## Interface
Parameters:
- `SETS`, 64: number of cache lines; power of 2, 2..256.
- `LINE_WORDS`, 2: 32-bit words per line; 1, 2 or 4.
- `WAIT_CYCLES`, 5: extra cycles per SRAM halfword access; 1..15. Slot length S = WAIT_CYCLES+1.
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `MEMread` in 1: load request.
- `MEMwrite` in 1: store request. If both `MEMread` and `MEMwrite` are set, the request is treated as a store.
- `WB_EN` in 1: write-back enable from EXE/MEM.
- `address` in 32: byte address from ALU.
- `data` in 32: store data.
- `MEM_result` out 32: load data.
- `freeze_signal` out 1: stall request to the pipeline.
- `WB_EN_Out` out 1: equals `WB_EN` when `freeze_signal`=0, else 0.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: halfword address.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N` out 1 each: tied 0.
- `SRAM_WE_N` out 1: write strobe, active low.
- `SRAM_OE_N` out 1: output enable, active low.

## Operation
Address mapping:
- Word address `wa = ((address - BASE_ADDR) >> 2) mod 2^17`.
- Bits: offset = `wa[log2 LINE_WORDS-1:0]`; index = next `log2 SETS` bits; tag = remaining bits of the 17.
- Word `wa` occupies SRAM halfwords `2*wa` (bits 15:0) and `2*wa+1` (bits 31:16).

Storage per set: valid bit, tag, `LINE_WORDS`×32 data.

Hit: `hit = valid[index] & tag match`.

State machine (IDLE, FILL, WRITE, DONE):
- **IDLE**
  - Store: go to WRITE. Counters: halfword counter h=0, wait counter w=0.
  - Load miss: go to FILL, h=0, w=0.
  - Load hit or no request: stay in IDLE.
- **FILL**
  - Reads 2·`LINE_WORDS` halfwords starting at halfword `2*(wa & ~(LINE_WORDS-1))`, in ascending order.
  - Each halfword occupies a slot of S cycles. `SRAM_ADDR` is held for the whole slot; `SRAM_OE_N`=0 throughout FILL.
  - `SRAM_DQ` is sampled into the line buffer on the last cycle of each slot (w=WAIT_CYCLES).
  - After the last slot: write the line, tag and valid=1 into the set, then go to DONE.
- **WRITE**
  - Writes the low halfword then the high halfword of `data`, one slot each.
  - `SRAM_DQ` and `SRAM_ADDR` are driven for the whole slot. `SRAM_WE_N`=0 for w=0..WAIT_CYCLES-1 and 1 at w=WAIT_CYCLES, so data is held past the WE rising edge.
  - On a hit, the cached word is updated at WRITE entry. On a miss, the cache is untouched.
  - After 2 slots, go to DONE.
- **DONE**
  - Lasts one cycle, then returns to IDLE.
  - Exists so that the still-presented request is not re-issued.

`SRAM_DQ` is high-Z outside WRITE.

Outputs:
- `freeze_signal`
  - IDLE: combinational, `MEMwrite | (MEMread & ~hit)`.
  - FILL and WRITE: 1.
  - DONE: 0.
- `MEM_result`
  - Combinational: the cache word at the offset selected by `address`.
  - Valid whenever `MEMread` is set and `freeze_signal`=0.
  - Otherwise unspecified.

Pipeline contract: while `freeze_signal`=1, the pipeline holds `address`, `data`, `MEMread` and `MEMwrite` stable. The block does not re-latch them.

## Timing
Reset (async, immediate):
- State IDLE, all valid bits 0, h=w=0.
- `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_ADDR`=0, `SRAM_DQ` high-Z.
- Reset mid-FILL or mid-WRITE aborts the access. The partial line is discarded (valid stays 0).

Latency (request arriving in IDLE at cycle 0):
- Load hit: 0 cycles; `freeze_signal`=0.
- Load miss: `freeze_signal`=1 for cycles 0..2·`LINE_WORDS`·S. DONE occurs at cycle 2·`LINE_WORDS`·S+1, with data valid and freeze=0.
- Store (hit or miss): freeze=1 for cycles 0..2S. DONE occurs at 2S+1.

Boundary behaviour:
- A request present in DONE is ignored.
- A new request is accepted in the following IDLE cycle.
- Back-to-back identical stores therefore both execute.
- Addresses below `BASE_ADDR` wrap modulo 2^17 words.

## Test plan
- Defaults, reset, then load from 1024 (SRAM hw0=0x5678, hw1=0x1234) → freeze high 25 cycles; `SRAM_ADDR` steps 0,1,2,3 every 6 cycles; `MEM_result`=0x12345678 in DONE; an immediate reload of 1024 hits with 0 freeze.
- Store 0xDEADBEEF to 1032 (miss) → freeze 13 cycles; `SRAM_ADDR` 4 then 5, DQ 0xBEEF then 0xDEAD; WE_N low 5 of each 6 cycles; a later load of 1032 misses and returns 0xDEADBEEF.
- Load 1024 (fill), then store 0xCAFEF00D to 1028 → store is a hit and updates the line; next load of 1028 returns 0xCAFEF00D with 0 freeze.
- Conflict: with `SETS`=64 and `LINE_WORDS`=2, load 1024 then load 1024+512 (same index) → second load misses and refills; reload of 1024 misses again.
- Assert `rst` at FILL cycle 10 → `SRAM_OE_N`=1 and DQ high-Z immediately; the subsequent load to the same address misses.
- `LINE_WORDS`=4, `WAIT_CYCLES`=1: load miss → freeze 17 cycles; 8 halfword addresses are read; `WB_EN_Out`=0 throughout freeze and equals `WB_EN` in DONE.
